// File: rtl/spi_byte_arbiter_pkg.sv
// spi_arb_pkg: FSM state type, default requester count, byte width, one-hot to index helper
package spi_arb_pkg;
  localparam int NREQ_DEF = 3;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    oh2idx = '0;
    for (int i = 0; i < 8; i++) if (oh[i]) oh2idx = 3'(i);
  endfunction
endpackage

// File: rtl/spi_byte_arbiter_if.sv
// spi_byte_arbiter_if: requester side (req/reqLast/reqData in, gnt/ack/rspValid/rspData/busy out) and SPI master side (ready/arrived/dataR in, send/data out); master = arbiter view, slave = environment view
interface spi_byte_arbiter_if import spi_arb_pkg::*; #(parameter int NREQ = NREQ_DEF);
  logic [NREQ-1:0] req, reqLast, gnt, ack, rspValid;
  logic [BYTE_W*NREQ-1:0] reqData;
  logic [BYTE_W-1:0] rspData, data, dataR;
  logic busy, ready, send, arrived;
  modport master(
    input req, reqLast, reqData, ready, arrived, dataR,
    output gnt, ack, rspValid, rspData, busy, send, data
  );
  modport slave(
    output req, reqLast, reqData, ready, arrived, dataR,
    input gnt, ack, rspValid, rspData, busy, send, data
  );
endinterface

// File: rtl/spi_byte_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; ports req/rrPtr in, one-hot grant (first requester at or after rrPtr) and valid out
module rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rrPtr,
  output logic [NREQ-1:0]         grant,
  output logic                    valid
);
  logic [NREQ-1:0] low, pick;
  assign low = NREQ'({req, req} >> rrPtr);
  assign pick = low & (~low + 1'b1);
  assign grant = NREQ'(({pick, pick} << rrPtr) >> NREQ);
  assign valid = |req;
endmodule

// File: rtl/spi_byte_arbiter.sv
// spi_byte_arbiter: round-robin, transaction-locked sharing of one SPI byte master; ports clk, rst_n (async active-low), bus (spi_byte_arbiter_if.master: requester and SPI master signals)
module spi_byte_arbiter import spi_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int HOLD_TIMEOUT = 1024
) (
  input logic clk,
  input logic rst_n,
  spi_byte_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  localparam int HW = HOLD_TIMEOUT > 1 ? $clog2(HOLD_TIMEOUT) : 1;
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, rr_ptr_n, own, own_inc;
  logic [HW-1:0] hold, hold_n;
  logic last, last_n, send_n, pick_valid, rel;
  logic [NREQ-1:0] pick, gnt_n, ack_n, rsp_valid_n;
  logic [BYTE_W-1:0] rsp_data_n, data_n;
  rr_pick #(.NREQ(NREQ)) u_pick (.req(bus.req), .rrPtr(rr_ptr), .grant(pick), .valid(pick_valid));
  assign own = IW'(oh2idx(8'(bus.gnt)));
  assign own_inc = (own == IW'(NREQ - 1)) ? '0 : own + 1'b1;
  always_comb begin
    state_n = state;
    rr_ptr_n = rr_ptr;
    hold_n = hold;
    last_n = last;
    gnt_n = bus.gnt;
    ack_n = '0;
    rsp_valid_n = '0;
    rsp_data_n = bus.rspData;
    send_n = 1'b0;
    data_n = bus.data;
    rel = 1'b0;
    case (state)
      IDLE: if (pick_valid) begin
        gnt_n = pick;
        hold_n = '0;
        state_n = ISSUE;
      end
      ISSUE: if (bus.req[own] && bus.ready) begin
        send_n = 1'b1;
        data_n = bus.reqData[{own, 3'b000} +: BYTE_W];
        ack_n = bus.gnt;
        last_n = bus.reqLast[own];
        hold_n = '0;
        state_n = WAIT;
      end else if (!bus.req[own]) begin
        rel = hold == HW'(HOLD_TIMEOUT - 1);
        hold_n = rel ? hold : hold + 1'b1;
      end
      WAIT: if (bus.arrived) begin
        rsp_valid_n = bus.gnt;
        rsp_data_n = bus.dataR;
        rel = last;
        state_n = ISSUE;
      end
      default: state_n = IDLE;
    endcase
    if (rel) begin
      gnt_n = '0;
      rr_ptr_n = own_inc;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      hold <= '0;
      last <= 1'b0;
      bus.gnt <= '0;
      bus.ack <= '0;
      bus.rspValid <= '0;
      bus.rspData <= '0;
      bus.send <= 1'b0;
      bus.data <= '0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_ptr_n;
      hold <= hold_n;
      last <= last_n;
      bus.gnt <= gnt_n;
      bus.ack <= ack_n;
      bus.rspValid <= rsp_valid_n;
      bus.rspData <= rsp_data_n;
      bus.send <= send_n;
      bus.data <= data_n;
      bus.busy <= |gnt_n;
    end
  end
endmodule

// File: tb/tb_spi_byte_arbiter.sv
// tb_spi_byte_arbiter: directed scenarios plus randomized traffic checked against a transaction-level owner model
module tb_spi_byte_arbiter;
  import spi_arb_pkg::*;
  localparam int N = 3;
  localparam int HOLD = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;
  spi_byte_arbiter_if #(.NREQ(N)) bus();
  spi_byte_arbiter #(.NREQ(N), .HOLD_TIMEOUT(HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int m_lat = 2;
  bit m_stall = 1'b0;
  bit m_rnd = 1'b0;
  bit m_fix = 1'b1;
  logic [7:0] m_byte = 8'hA5;
  int cnt = 0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt = 0;
      bus.ready = 1'b1;
      bus.arrived = 1'b0;
      bus.dataR = '0;
    end else begin
      bus.arrived = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.arrived = 1'b1;
          bus.dataR = m_fix ? m_byte : 8'($urandom);
        end
      end else if (bus.send) begin
        cnt = m_lat > 0 ? m_lat : int'($urandom_range(1, 4));
        bus.ready = 1'b0;
      end else begin
        bus.ready = !m_stall && !(m_rnd && $urandom_range(0, 4) == 0);
        if (m_rnd && $urandom_range(0, 19) == 0) begin
          bus.arrived = 1'b1;
          bus.dataR = 8'($urandom);
        end
      end
    end
  end
  logic [N-1:0] e_gnt = '0, e_ack = '0, e_rv = '0;
  logic [7:0] e_rd = '0, e_data = '0;
  logic e_send = 1'b0, e_busy = 1'b0;
  int owner = -1, ptr = 0, idle = 0;
  bit outst = 1'b0, lastf = 1'b0, done = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_gnt = '0; e_ack = '0; e_rv = '0; e_rd = '0; e_data = '0; e_send = 1'b0; e_busy = 1'b0;
      owner = -1; ptr = 0; idle = 0; outst = 1'b0; lastf = 1'b0;
    end else begin
      e_send = 1'b0; e_ack = '0; e_rv = '0; done = 1'b0;
      if (owner < 0) begin
        for (int k = 0; k < N; k++) if (owner < 0 && bus.req[(ptr + k) % N]) owner = (ptr + k) % N;
        idle = 0;
      end else if (outst) begin
        if (bus.arrived) begin
          e_rv[owner] = 1'b1;
          e_rd = bus.dataR;
          outst = 1'b0;
          done = lastf;
        end
      end else if (bus.req[owner] && bus.ready) begin
        e_send = 1'b1;
        e_data = bus.reqData[owner*8 +: 8];
        e_ack[owner] = 1'b1;
        lastf = bus.reqLast[owner];
        outst = 1'b1;
        idle = 0;
      end else if (!bus.req[owner]) begin
        idle++;
        done = idle >= HOLD;
      end
      if (done) begin
        ptr = (owner + 1) % N;
        owner = -1;
      end
      e_gnt = owner < 0 ? '0 : N'(1) << owner;
      e_busy = owner >= 0;
    end
  end
  always @(negedge clk) begin
    n_cmp++;
    if (bus.gnt !== e_gnt || bus.ack !== e_ack || bus.rspValid !== e_rv || bus.rspData !== e_rd ||
        bus.busy !== e_busy || bus.send !== e_send || bus.data !== e_data) begin
      n_fail++;
      $display("FAIL cycle t=%0t got/want gnt=%b/%b ack=%b/%b rspValid=%b/%b rspData=%h/%h busy=%b/%b send=%b/%b data=%h/%h",
               $time, bus.gnt, e_gnt, bus.ack, e_ack, bus.rspValid, e_rv, bus.rspData, e_rd,
               bus.busy, e_busy, bus.send, e_send, bus.data, e_data);
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_for(input int which, input string nm);
    int t = 0;
    do begin
      tick();
      t++;
    end while (!(which == 0 ? bus.send : which == 1 ? |bus.rspValid : bus.gnt != '0) && t < 200);
    if (t >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: waited %0d cycles, expected event within 200", nm, t);
    end
  endtask
  task automatic set_r(input int i, input bit r, input bit l, input logic [7:0] d);
    bus.req[i] = r;
    bus.reqLast[i] = l;
    bus.reqData[i*8 +: 8] = d;
  endtask
  int rem[N];
  int gap[N];
  task automatic new_byte(input int i);
    bus.reqData[i*8 +: 8] = 8'($urandom);
    bus.reqLast[i] = rem[i] == 1;
  endtask
  task automatic rnd_step();
    for (int i = 0; i < N; i++) begin
      if (bus.ack[i]) begin
        rem[i]--;
        if (rem[i] == 0) begin
          bus.req[i] = 1'b0;
          gap[i] = int'($urandom_range(0, 5));
        end else begin
          bus.req[i] = $urandom_range(0, 5) != 0;
          gap[i] = bus.req[i] ? 0 : int'($urandom_range(0, 24));
          new_byte(i);
        end
      end else if (!bus.req[i]) begin
        if (gap[i] > 0) gap[i]--;
        else begin
          if (rem[i] == 0) rem[i] = int'($urandom_range(1, 4));
          new_byte(i);
          bus.req[i] = 1'b1;
        end
      end
    end
  endtask
  int sends, t;
  initial begin
    bus.req = '0;
    bus.reqLast = '0;
    bus.reqData = '0;
    #1 rst_n = 1'b0;
    tick();
    check("reset gnt", bus.gnt, 0);
    check("reset busy", bus.busy, 0);
    check("reset send", bus.send, 0);
    check("reset rspValid", bus.rspValid, 0);
    tick();
    rst_n = 1'b1;
    set_r(0, 1, 1, 8'h42);
    tick();
    check("t1 gnt cycle1", bus.gnt, 3'b001);
    check("t1 model gnt", e_gnt, 3'b001);
    check("t1 no send cycle1", bus.send, 0);
    tick();
    check("t1 send cycle2", bus.send, 1);
    check("t1 data", bus.data, 8'h42);
    check("t1 ack", bus.ack, 3'b001);
    check("t1 model data", e_data, 8'h42);
    set_r(0, 0, 0, 8'h00);
    wait_for(1, "t1 rsp");
    check("t1 rspValid", bus.rspValid, 3'b001);
    check("t1 rspData", bus.rspData, 8'hA5);
    check("t1 gnt released", bus.gnt, 0);
    check("t1 busy released", bus.busy, 0);
    tick(2);
    set_r(1, 1, 0, 8'h01);
    set_r(2, 1, 1, 8'h77);
    for (int b = 1; b <= 3; b++) begin
      wait_for(0, "t2 send");
      check("t2 gnt locked", bus.gnt, 3'b010);
      check("t2 data", bus.data, b);
      check("t2 ack", bus.ack, 3'b010);
      if (b < 3) set_r(1, 1, b == 2, 8'(b + 1));
      else set_r(1, 0, 0, 8'h00);
    end
    wait_for(1, "t2 last rsp");
    check("t2 rsp owner", bus.rspValid, 3'b010);
    check("t2 released", bus.gnt, 0);
    tick();
    check("t2 next grant", bus.gnt, 3'b100);
    wait_for(0, "t2 req2 send");
    check("t2 req2 ack", bus.ack, 3'b100);
    check("t2 req2 data", bus.data, 8'h77);
    set_r(2, 0, 0, 8'h00);
    wait_for(1, "t2 req2 rsp");
    tick(2);
    m_lat = 1;
    for (int i = 0; i < N; i++) set_r(i, 1, 1, 8'(8'h10 + i));
    for (int s = 0; s < 6; s++) begin
      wait_for(0, "t3 send");
      check("t3 grant order", bus.ack, 32'(1 << (s % 3)));
      check("t3 data", bus.data, 8'h10 + s % 3);
      if (s == 5) bus.req = '0;
    end
    wait_for(1, "t3 rsp");
    tick(2);
    m_lat = 2;
    set_r(0, 1, 0, 8'h55);
    set_r(1, 1, 1, 8'h66);
    wait_for(0, "t4 send");
    check("t4 ack", bus.ack, 3'b001);
    set_r(0, 0, 0, 8'h00);
    wait_for(1, "t4 rsp");
    t = 0;
    sends = 0;
    do begin
      tick();
      t++;
      sends += int'(bus.send);
    end while (bus.gnt == 3'b001 && t < 100);
    check("t4 hold cycles", t, HOLD);
    check("t4 no send in hold", sends, 0);
    check("t4 released", bus.gnt, 0);
    tick();
    check("t4 next grant", bus.gnt, 3'b010);
    wait_for(0, "t4 req1 send");
    check("t4 req1 data", bus.data, 8'h66);
    set_r(1, 0, 0, 8'h00);
    wait_for(1, "t4 req1 rsp");
    tick(2);
    m_stall = 1'b1;
    set_r(2, 1, 1, 8'h99);
    sends = 0;
    repeat (50) begin
      tick();
      sends += int'(bus.send);
    end
    check("t5 no send while not ready", sends, 0);
    check("t5 gnt held", bus.gnt, 3'b100);
    m_stall = 1'b0;
    sends = 0;
    repeat (10) begin
      tick();
      sends += int'(bus.send);
      if (bus.ack[2]) set_r(2, 0, 0, 8'h00);
    end
    check("t5 one send", sends, 1);
    tick(2);
    m_lat = 6;
    set_r(1, 1, 1, 8'h3C);
    wait_for(0, "t6 send");
    set_r(1, 0, 0, 8'h00);
    tick();
    #2 rst_n = 1'b0;
    set_r(2, 1, 1, 8'hC3);
    #1;
    check("t6 rst gnt", bus.gnt, 0);
    check("t6 rst busy", bus.busy, 0);
    check("t6 rst send", bus.send, 0);
    check("t6 rst data", bus.data, 0);
    check("t6 rst rspData", bus.rspData, 0);
    check("t6 rst ack", bus.ack, 0);
    check("t6 rst rspValid", bus.rspValid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6 grant after reset", bus.gnt, 3'b100);
    wait_for(0, "t6 send after reset");
    check("t6 data after reset", bus.data, 8'hC3);
    set_r(2, 0, 0, 8'h00);
    wait_for(1, "t6 rsp");
    tick(2);
    m_fix = 1'b0;
    m_lat = 0;
    m_rnd = 1'b1;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      gap[i] = 0;
    end
    repeat (3000) begin
      tick();
      rnd_step();
    end
    bus.req = '0;
    m_rnd = 1'b0;
    tick(60);
    check("drain idle", bus.busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
